// File: rtl/cdc_handshake_pkg.sv
// Shared types for the 4-phase req/ack source-side crossing controller.
package cdc_handshake_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } state_e;

endpackage

// File: rtl/cdc_handshake_src_sync.sv
// Multi-flop level synchronizer with synchronous active-low clear.
module cdc_handshake_src_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_handshake_src.sv
// Source-side controller for a 4-phase req/ack crossing of one data word,
// with completion pulse and sticky timeout while waiting for ack.
module cdc_handshake_src
    import cdc_handshake_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  req_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  ack_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  timeout_o,
    input  logic                  clr_timeout_i
);

    localparam int unsigned CNT_W =
        (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned TERM  = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TERM);

    state_e                state_q, state_d;
    logic                  req_q, req_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ok_q, ok_d;
    logic                  done_q, done_d;
    logic                  timeout_q, timeout_d;
    logic                  timeout_set;
    logic                  ack_s;

    cdc_handshake_src_sync #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (ack_i),
        .q_o    (ack_s)
    );

    // A stale ack seen in IDLE must drain before a new word is taken.
    assign ready_o   = (state_q == IDLE) && !ack_s;
    assign busy_o    = (state_q != IDLE);
    assign req_o     = req_q;
    assign data_o    = data_q;
    assign done_o    = done_q;
    assign timeout_o = timeout_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            data_q    <= '0;
            cnt_q     <= '0;
            ok_q      <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            ok_q      <= ok_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        ok_d        = ok_q;
        done_d      = 1'b0;
        timeout_set = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (valid_i && ready_o) begin
                    data_d  = data_i;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    ok_d    = 1'b0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // Ack outranks a coincident terminal count.
                if (ack_s) begin
                    req_d   = 1'b0;
                    ok_d    = 1'b1;
                    state_d = RELEASE;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_TERM)) begin
                    req_d       = 1'b0;
                    ok_d        = 1'b0;
                    timeout_set = 1'b1;
                    state_d     = RELEASE;
                end
            end
            RELEASE: begin
                if (!ack_s) begin
                    done_d  = ok_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        if (timeout_set) begin
            timeout_d = 1'b1;
        end else if (clr_timeout_i) begin
            timeout_d = 1'b0;
        end else begin
            timeout_d = timeout_q;
        end
    end

endmodule

// File: tb/tb_cdc_handshake_src.sv
// Directed bench for cdc_handshake_src (DATA_WIDTH=8, SYNC_STAGES=2, TIMEOUT_CYCLES=16).
module tb_cdc_handshake_src;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid;
    logic       ready;
    logic [7:0] data_in;
    logic       req;
    logic [7:0] data_out;
    logic       ack = 1'b0;
    logic       busy;
    logic       done;
    logic       timeout;
    logic       clr;

    int         checks = 0;
    int         errors = 0;

    // Remote model: 0 = manual level, 1 = req delayed a few cycles, 2 = immediate echo.
    int         mode = 0;
    logic       ack_man = 1'b0;
    logic [1:0] hist = 2'b00;

    cdc_handshake_src #(
        .DATA_WIDTH     (8),
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .valid_i       (valid),
        .ready_o       (ready),
        .data_i        (data_in),
        .req_o         (req),
        .data_o        (data_out),
        .ack_i         (ack),
        .busy_o        (busy),
        .done_o        (done),
        .timeout_o     (timeout),
        .clr_timeout_i (clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        hist <= {hist[0], req};
        case (mode)
            0:       ack <= ack_man;
            1:       ack <= hist[1];
            default: ack <= req;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid = 1'b0; data_in = 8'h00; clr = 1'b0;
        mode = 0; ack_man = 1'b0;
        repeat (3) step();
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", req); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
        rst_n = 1'b1;
        step();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
    endtask

    task automatic test_basic();
        logic data_ok;
        logic ended;
        int   dones;
        mode = 1;
        valid = 1'b1; data_in = 8'hA5;
        step();
        valid = 1'b0;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL basic_ready: got %b expected 0", ready); end
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL basic_req: got %b expected 1", req); end
        checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", data_out); end
        data_ok = 1'b1; ended = 1'b0; dones = 0;
        for (int i = 0; i < 40 && !ended; i++) begin
            step();
            if (done === 1'b1) dones++;
            if (data_out !== 8'hA5) data_ok = 1'b0;
            if (busy === 1'b0) ended = 1'b1;
        end
        checks++; if (ended !== 1'b1) begin errors++; $display("FAIL basic_complete: got %b expected 1", ended); end
        checks++; if (dones != 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", dones); end
        checks++; if (data_ok !== 1'b1) begin errors++; $display("FAIL basic_data_stable: got %b expected 1", data_ok); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL basic_timeout: got %b expected 0", timeout); end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_single: got %b expected 0", done); end
    endtask

    task automatic test_timeout();
        int   req_cycles;
        int   dones;
        logic fell;
        mode = 0; ack_man = 1'b0;
        valid = 1'b1; data_in = 8'h77;
        step();
        valid = 1'b0;
        req_cycles = (req === 1'b1) ? 1 : 0;
        fell = 1'b0; dones = 0;
        for (int i = 0; i < 40 && !fell; i++) begin
            step();
            if (done === 1'b1) dones++;
            if (req === 1'b1) req_cycles++;
            else fell = 1'b1;
        end
        checks++; if (req_cycles != 16) begin errors++; $display("FAIL to_req_cycles: got %0d expected 16", req_cycles); end
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_flag: got %b expected 1", timeout); end
        step();
        if (done === 1'b1) dones++;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL to_ready: got %b expected 1", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_busy: got %b expected 0", busy); end
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", timeout); end
        checks++; if (dones != 0) begin errors++; $display("FAIL to_no_done: got %0d expected 0", dones); end
    endtask

    task automatic test_stale_ack();
        logic found;
        logic early;
        logic got;
        int   dones;
        mode = 0; ack_man = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            step();
            if (ready === 1'b0) found = 1'b1;
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL stale_ready_low: got %b expected 1", found); end
        valid = 1'b1; data_in = 8'h3C;
        early = 1'b0;
        repeat (7) begin
            step();
            if (busy !== 1'b0 || ready !== 1'b0) early = 1'b1;
        end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL stale_blocked: got %b expected 0", early); end
        ack_man = 1'b0; mode = 1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (req === 1'b1) got = 1'b1;
        end
        valid = 1'b0;
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL stale_accept: got %b expected 1", got); end
        checks++; if (data_out !== 8'h3C) begin errors++; $display("FAIL stale_data: got %h expected 3c", data_out); end
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL stale_timeout_kept: got %b expected 1", timeout); end
        dones = 0;
        for (int i = 0; i < 40 && dones == 0; i++) begin
            step();
            if (done === 1'b1) dones++;
        end
        checks++; if (dones != 1) begin errors++; $display("FAIL stale_done: got %0d expected 1", dones); end
    endtask

    task automatic test_clr_collision();
        mode = 0; ack_man = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL clr_alone: got %b expected 0", timeout); end
        valid = 1'b1; data_in = 8'h11;
        step();
        valid = 1'b0;
        repeat (15) step();
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL clr_pre_term_req: got %b expected 1", req); end
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL clr_collision: got %b expected 1", timeout); end
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL clr_req_fall: got %b expected 0", req); end
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL clr_after: got %b expected 0", timeout); end
    endtask

    task automatic test_reset_mid();
        int dones;
        mode = 0; ack_man = 1'b0;
        valid = 1'b1; data_in = 8'h99;
        step();
        valid = 1'b0;
        step();
        step();
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL rstmid_pre_req: got %b expected 1", req); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL rstmid_req: got %b expected 0", req); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h expected 00", data_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b expected 0", done); end
        repeat (3) step();
        mode = 1;
        valid = 1'b1; data_in = 8'h5A;
        step();
        valid = 1'b0;
        checks++; if (req !== 1'b1 || data_out !== 8'h5A) begin
            errors++; $display("FAIL rstmid_new_xfer: got req=%b data=%h expected req=1 data=5a", req, data_out);
        end
        dones = 0;
        for (int i = 0; i < 40 && dones == 0; i++) begin
            step();
            if (done === 1'b1) dones++;
        end
        checks++; if (dones != 1) begin errors++; $display("FAIL rstmid_done_after: got %0d expected 1", dones); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rstmid_timeout: got %b expected 0", timeout); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] cap [3];
        logic [7:0] cur;
        logic       prev;
        logic       stable;
        int         rises;
        int         dones;
        mode = 2;
        valid = 1'b1; data_in = 8'h01;
        cur = 8'h00; prev = req; stable = 1'b1; rises = 0; dones = 0;
        for (int k = 0; k < 3; k++) cap[k] = 8'hFF;
        for (int i = 0; i < 120 && dones < 3; i++) begin
            step();
            if (done === 1'b1) dones++;
            if (req === 1'b1 && prev === 1'b0) begin
                if (rises < 3) cap[rises] = data_out;
                cur = data_out;
                rises++;
                if (rises < 3) data_in = 8'(rises + 1);
                else valid = 1'b0;
            end else if (busy === 1'b1 && data_out !== cur) begin
                stable = 1'b0;
            end
            prev = req;
        end
        valid = 1'b0;
        checks++; if (rises != 3) begin errors++; $display("FAIL b2b_req_rises: got %0d expected 3", rises); end
        checks++; if (dones != 3) begin errors++; $display("FAIL b2b_dones: got %0d expected 3", dones); end
        checks++; if (cap[0] !== 8'h01) begin errors++; $display("FAIL b2b_data0: got %h expected 01", cap[0]); end
        checks++; if (cap[1] !== 8'h02) begin errors++; $display("FAIL b2b_data1: got %h expected 02", cap[1]); end
        checks++; if (cap[2] !== 8'h03) begin errors++; $display("FAIL b2b_data2: got %h expected 03", cap[2]); end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL b2b_data_stable: got %b expected 1", stable); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_stale_ack();
        test_clr_collision();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
